// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory into a
// small FIFO of {pc, instr} entries, with redirect (flush + refetch) support.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  input  logic        fetch_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  localparam int          PW       = $clog2(DEPTH);
  localparam int          CW       = PW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   hold_addr_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] head_reg, tail_reg;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          push, pop;
  logic [31:0]   target_aligned;

  assign target_aligned = {redirect_target[31:2], 2'b00};
  // A redirect outranks both queue operations; the flush wins in the same edge.
  assign push = (state_reg == REQ) && mem_ack && !redirect;
  assign pop  = fetch_ready && (count_reg != '0) && !redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (redirect || count_reg != FULL) state_next = REQ;
      REQ: begin
        if (mem_ack)       state_next = IDLE;
        else if (redirect) state_next = DROP;
      end
      DROP: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DROP keeps presenting the abandoned address until memory acknowledges it.
  always_comb begin
    mem_req  = (state_reg == REQ) || (state_reg == DROP);
    mem_addr = (state_reg == DROP) ? hold_addr_reg : fetch_pc_reg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg  <= START_PC;
      hold_addr_reg <= START_PC;
      count_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      if (state_reg == REQ) hold_addr_reg <= fetch_pc_reg;
      if (redirect) begin
        fetch_pc_reg <= target_aligned;
        count_reg    <= '0;
        head_reg     <= '0;
        tail_reg     <= '0;
      end else begin
        if (push) begin
          instr_mem[tail_reg] <= mem_rdata;
          pc_mem[tail_reg]    <= fetch_pc_reg;
          tail_reg            <= tail_reg + PW'(1);
          fetch_pc_reg        <= fetch_pc_reg + 32'd4;
        end
        if (pop) head_reg <= head_reg + PW'(1);
        if (push && !pop)      count_reg <= count_reg + CW'(1);
        else if (pop && !push) count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign instr_valid  = (count_reg != '0);
  assign instr_out    = instr_mem[head_reg];
  assign pc_out       = pc_mem[head_reg];
  assign pc_plus4_out = pc_out + 32'd4;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios plus a randomized run
// against a transaction-level queue model.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic        fetch_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .fetch_ready(fetch_ready), .redirect(redirect), .redirect_target(redirect_target)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // memory responder settings
  int lat = 0;
  int wait_cnt = 0;
  bit rand_mode = 0;

  // reference model: entry queue plus one outstanding-request record
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_busy, m_drop;
  logic [31:0] m_addr;

  task automatic model_reset();
    q.delete();
    m_pc = 32'h0; m_busy = 0; m_drop = 0; m_addr = 32'h0;
  endtask

  task automatic model_step();
    int sz;
    bit start;
    if (!reset_n) begin model_reset(); return; end
    sz = q.size();
    start = 0;
    if (fetch_ready && sz > 0 && !redirect) void'(q.pop_front());
    if (m_busy) begin
      if (mem_ack) begin
        if (!m_drop && !redirect) begin
          q.push_back('{pc: m_addr, ins: mem_rdata});
          m_pc = m_pc + 32'd4;
        end
        m_busy = 0;
      end else if (redirect) m_drop = 1;
    end else if (redirect || sz < DEPTH) begin
      m_busy = 1; m_drop = 0; start = 1;
    end
    if (redirect) begin q.delete(); m_pc = {redirect_target[31:2], 2'b00}; end
    if (start) m_addr = m_pc;
  endtask

  task automatic drive_mem();
    if (mem_req) begin
      mem_rdata = rand_mode ? $urandom : ~mem_addr;
      if (wait_cnt >= lat) begin
        mem_ack = 1'b1; wait_cnt = 0;
        if (rand_mode) lat = $urandom_range(0, 3);
      end else begin
        mem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      mem_ack = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock); #1;
    drive_mem();
  endtask

  task automatic do_reset();
    fetch_ready = 0; redirect = 0; redirect_target = '0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", instr_valid); else n_pass++;
    n_checks++; if (instr_out !== 32'h0) $display("FAIL reset_instr got %h want 0", instr_out); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", mem_addr); else n_pass++;
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_fill();
    lat = 0; rand_mode = 0;
    tick(); tick();
    n_checks++; if (instr_valid !== 1'b1) $display("FAIL first_valid got %0b want 1", instr_valid); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL first_pc got %h want 0", pc_out); else n_pass++;
    n_checks++; if (instr_out !== 32'hFFFF_FFFF) $display("FAIL first_instr got %h want ffffffff", instr_out); else n_pass++;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mem_req !== 1'b0) $display("FAIL full_no_req cyc %0d got %0b want 0", i, mem_req); else n_pass++;
    end
    n_checks++; if (mem_addr !== 32'h10) $display("FAIL full_addr got %h want 10", mem_addr); else n_pass++;
    $display("test_fill done");
  endtask

  task automatic test_pop_one();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h8; exp_pc[1] = 32'hC; exp_pc[2] = 32'h10;
    fetch_ready = 1; tick(); fetch_ready = 0;
    n_checks++; if (pc_out !== 32'h4) $display("FAIL pop_pc got %h want 4", pc_out); else n_pass++;
    n_checks++; if (pc_plus4_out !== 32'h8) $display("FAIL pop_pc4 got %h want 8", pc_plus4_out); else n_pass++;
    n_checks++; if (instr_out !== ~32'h4) $display("FAIL pop_instr got %h want %h", instr_out, ~32'h4); else n_pass++;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) $display("FAIL refill_req got %0b/%h want 1/10", mem_req, mem_addr); else n_pass++;
    tick(); tick();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL refill_once got %0b want 0", mem_req); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      fetch_ready = 1; tick(); fetch_ready = 0;
      n_checks++; if (pc_out !== exp_pc[i]) $display("FAIL drain_pc %0d got %h want %h", i, pc_out, exp_pc[i]); else n_pass++;
    end
    $display("test_pop_one done");
  endtask

  task automatic test_drop();
    do_reset(); lat = 3;
    tick(); tick();
    redirect = 1; redirect_target = 32'h100; tick(); redirect = 0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL drop_hold got %0b/%h want 1/0", mem_req, mem_addr); else n_pass++;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL drop_hold2 got %0b/%h want 1/0", mem_req, mem_addr); else n_pass++;
    lat = 0; tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL drop_discard got %0b want 0", instr_valid); else n_pass++;
    n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h100) $display("FAIL drop_idle got %0b/%h want 0/100", mem_req, mem_addr); else n_pass++;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL drop_next got %0b/%h want 1/100", mem_req, mem_addr); else n_pass++;
    $display("test_drop done");
  endtask

  task automatic test_redirect_collision();
    do_reset(); lat = 0;
    repeat (5) tick();
    n_checks++; if (mem_req !== 1'b1 || mem_ack !== 1'b1 || instr_valid !== 1'b1) $display("FAIL coll_setup got %0b%0b%0b want 111", mem_req, mem_ack, instr_valid); else n_pass++;
    redirect = 1; redirect_target = 32'h203; fetch_ready = 1;
    tick(); redirect = 0; fetch_ready = 0;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL coll_flush got %0b want 0", instr_valid); else n_pass++;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) $display("FAIL coll_next got %0b/%h want 1/200", mem_req, mem_addr); else n_pass++;
    tick();
    n_checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h200) $display("FAIL coll_push got %0b/%h want 1/200", instr_valid, pc_out); else n_pass++;
    $display("test_redirect_collision done");
  endtask

  task automatic test_wrap();
    do_reset(); lat = 0;
    redirect = 1; redirect_target = 32'hFFFF_FFFC; tick(); redirect = 0;
    n_checks++; if (mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req got %h want fffffffc", mem_addr); else n_pass++;
    tick();
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", pc_out); else n_pass++;
    n_checks++; if (pc_plus4_out !== 32'h0) $display("FAIL wrap_pc4 got %h want 0", pc_plus4_out); else n_pass++;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL wrap_next got %0b/%h want 1/0", mem_req, mem_addr); else n_pass++;
    $display("test_wrap done");
  endtask

  task automatic test_async_reset();
    do_reset(); lat = 0;
    repeat (5) tick();
    n_checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b1) $display("FAIL areset_setup got %0b/%0b want 1/1", mem_req, instr_valid); else n_pass++;
    #2 reset_n = 0; #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL areset_req got %0b want 0", mem_req); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h0) $display("FAIL areset_q got %0b/%h want 0/0", instr_valid, instr_out); else n_pass++;
    tick(); reset_n = 1;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL areset_restart got %0b/%h want 1/0", mem_req, mem_addr); else n_pass++;
    tick();
    n_checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0) $display("FAIL areset_first got %0b/%h want 1/0", instr_valid, pc_out); else n_pass++;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int errs_before;
    do_reset(); rand_mode = 1; lat = 1;
    errs_before = n_checks - n_pass;
    for (int c = 0; c < 3000; c++) begin
      tick();
      n_checks++; if (mem_req !== m_busy) $display("FAIL rnd_req cyc %0d got %0b want %0b", c, mem_req, m_busy); else n_pass++;
      n_checks++; if (mem_addr !== (m_busy ? m_addr : m_pc)) $display("FAIL rnd_addr cyc %0d got %h want %h", c, mem_addr, m_busy ? m_addr : m_pc); else n_pass++;
      n_checks++; if (instr_valid !== (q.size() != 0)) $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, instr_valid, q.size() != 0); else n_pass++;
      if (q.size() != 0) begin
        n_checks++; if (pc_out !== q[0].pc) $display("FAIL rnd_pc cyc %0d got %h want %h", c, pc_out, q[0].pc); else n_pass++;
        n_checks++; if (instr_out !== q[0].ins) $display("FAIL rnd_instr cyc %0d got %h want %h", c, instr_out, q[0].ins); else n_pass++;
        n_checks++; if (pc_plus4_out !== q[0].pc + 32'd4) $display("FAIL rnd_pc4 cyc %0d got %h want %h", c, pc_plus4_out, q[0].pc + 32'd4); else n_pass++;
      end
      fetch_ready = ($urandom_range(0, 1) == 1);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
      if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFE0 | {28'h0, redirect_target[3:0]};
    end
    redirect = 0; fetch_ready = 0; rand_mode = 0; lat = 0;
    $display("test_random done, %0d new failures", (n_checks - n_pass) - errs_before);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_pop_one();
    test_drop();
    test_redirect_collision();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port: clock  in  1  rising-edge clock for all state.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: mem_req  out  1  instruction-memory read request.
REQ-007 Port: mem_addr  out  32  word-aligned read address.
REQ-008 Port: mem_ack  in  1  read-data-valid strobe from memory.
REQ-009 Port: mem_rdata  in  32  instruction word from memory.
REQ-010 Port: instr_valid  out  1  head entry present.
REQ-011 Port: instr_out  out  32  head instruction.
REQ-012 Port: pc_out  out  32  address of the head instruction.
REQ-013 Port: pc_plus4_out  out  32  pc_out+4, modulo 2^32.
REQ-014 Port: fetch_ready  in  1  IF stage pops the head this cycle (PCWrite/IFIDWrite qualified).
REQ-015 Port: redirect  in  1  taken branch/jump; flush the queue and restart fetch.
REQ-016 Port: redirect_target  in  32  new fetch address.

Function
REQ-017 State machine SHALL have states IDLE, REQ and DROP; mem_req SHALL be 1 exactly in REQ and DROP.
REQ-018 mem_addr SHALL equal the registered fetch_pc in REQ, the held request address in DROP, and fetch_pc in IDLE; bits[1:0] SHALL always be 0.
REQ-019 Memory handshake: once mem_req=1, mem_req and mem_addr SHALL stay stable until a cycle with mem_ack=1; mem_ack outside REQ/DROP SHALL be ignored.
REQ-020 IDLE->REQ SHALL occur when count<DEPTH or redirect=1; otherwise the block SHALL stay in IDLE.
REQ-021 REQ with mem_ack=1 and redirect=0: push {fetch_pc, mem_rdata}, fetch_pc+=4 (wrap mod 2^32), go to IDLE.
REQ-022 REQ with redirect=1 and mem_ack=0: flush, fetch_pc=redirect_target with bits[1:0]=0, go to DROP.
REQ-023 REQ with redirect=1 and mem_ack=1: discard mem_rdata, flush, fetch_pc=target, go to IDLE.
REQ-024 DROP: on mem_ack=1, discard data and go to IDLE; redirect in DROP SHALL update fetch_pc and flush only.
REQ-025 Redirect in IDLE SHALL flush and load fetch_pc from the target.
REQ-026 Flush SHALL clear count, head and tail in the same edge; redirect SHALL override any simultaneous pop or push.
REQ-027 Pop SHALL occur when fetch_ready=1, count>0 and redirect=0; fetch_ready with count=0 SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; push with count=DEPTH SHALL be impossible by construction of REQ-020.
REQ-029 instr_valid=(count!=0); instr_out, pc_out and pc_plus4_out SHALL derive combinationally from registered head state only.
REQ-030 With zero-wait memory (mem_ack=1 whenever mem_req=1), throughput SHALL be one instruction per two cycles, and the first entry SHALL be visible 2 cycles after reset release.
REQ-031 Head and tail pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 On reset_n=0: state=IDLE, fetch_pc=RESET_PC, count=0, and pointers=0; mem_req=0, instr_valid=0, and instr_out=0 (queue storage SHALL be cleared).
REQ-033 Reset asserted mid-request SHALL drop mem_req immediately; the memory side SHALL tolerate an abandoned request.

Verification
REQ-034 Zero-wait memory, mem_rdata=addr^32'hFFFF_FFFF, fetch_ready=0 -> four entries at PCs 0, 4, 8 and C; mem_req stays 0 while full.
REQ-035 Full queue, then fetch_ready=1 for 1 cycle -> head PC 4, pc_plus4_out=8, and one new request to 0x10.
REQ-036 Memory with 3-cycle ack latency, redirect to 0x100 in the 2nd wait cycle -> state DROP, mem_addr held at old address; after ack, data discarded; next request to 0x100.
REQ-037 Redirect to 0x203 coinciding with mem_ack and fetch_ready -> queue empty next cycle, no push, and the next mem_addr is 0x200.
REQ-038 fetch_pc=0xFFFF_FFFC fetched -> pc_plus4_out=0, and the next mem_addr is 0.
REQ-039 Assert reset_n=0 while in REQ with two entries queued -> mem_req=0 and instr_valid=0 asynchronously; after release, fetch restarts at RESET_PC.
